fft_bfp_normalizer: RTL
=======================

# fft_bfp_normalizer

Downstream stage of the FFT core. Consumes the core's block-floating-point output stream (32-bit real/imag plus a per-frame signed exponent) and removes the exponent, giving fixed-scale OUT_W-bit samples with saturation. It also computes per-bin power, checks and regenerates frame delimiters, and forwards the result on a ready/valid stream to spectral post-processing.

## Interface
Parameters:
- FFT_N, 1024: points per frame; legal range ≥ 2.
- IN_W, 32: input sample width.
- OUT_W, 16: output sample width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_error  in  2  upstream error code.
- in_sop  in  1  first beat of a frame.
- in_eop  in  1  last beat of a frame.
- in_real  in  IN_W  signed.
- in_imag  in  IN_W  signed.
- in_exp  in  6  signed; true value = sample × 2^(−exp).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_error  out  2  bit0 = framing/upstream error; bit1 = saturation.
- out_sop  out  1  regenerated first beat of a frame.
- out_eop  out  1  regenerated last beat of a frame.
- out_real  out  OUT_W  signed, saturated.
- out_imag  out  OUT_W  signed, saturated.
- out_power  out  2·OUT_W  unsigned re²+im².
- err_sticky  out  2  OR of every out_error emitted since reset.

## Operation
- Shift s = −exp (range −31..32). s ≥ 0: left shift, saturating to OUT_W. s < 0: arithmetic right shift by −s (floor), then saturate. Bit1 sets if either component clips. Saturation limits are +2^(OUT_W−1)−1 and −2^(OUT_W−1).
- out_power = out_real² + out_imag², computed on the saturated values. The 2·OUT_W width is exact: the maximum is 2^(2·OUT_W−1).
- Exponent latching: the exponent is latched on the sop beat and used for the whole frame. in_exp on non-sop beats is ignored.
- FSM states:
  - IDLE: a beat with sop starts a frame (count←1, goes to INFRAME). A beat without sop is consumed, discarded and not emitted, and err_sticky[0] sets.
  - INFRAME, normal beat: count increments.
  - INFRAME, beat with sop: framing error. The frame restarts at this beat: out_sop=1, out_error[0]=1, count←1, the exponent is relatched.
  - INFRAME, eop arrives before count = FFT_N−1: out_eop=1, out_error[0]=1, goes to IDLE.
  - INFRAME, count = FFT_N−1 without eop: out_eop is forced to 1, out_error[0]=1, goes to IDLE.
  - INFRAME, normal completion (eop at count = FFT_N−1): goes to IDLE with no error.
- Non-zero in_error ORs into out_error[0] for that beat.
- out_sop/out_eop are driven from the counter/FSM, never passed straight through.

## Timing
- Two-stage pipeline: stage 1 does shift/saturate and framing; stage 2 does the squares and sum. Latency is 2 cycles from the accepted beat to out_valid.
- Stall-all flow control: in_ready = out_ready || !out_valid_stage2 || any bubble downstream of stage 1. No beat is lost or duplicated.
- While out_valid && !out_ready, all out_* hold stable.
- Throughput is 1 beat/clk with out_ready held high.
- Reset (also mid-frame): FSM → IDLE, count 0, stage valids 0. All outputs read 0: out_valid, out_sop, out_eop, out_error, out_real, out_imag, out_power, err_sticky. in_ready reads 1 in the cycle after reset deasserts.

## Structure
- Package fft_pkg holds:
  - EXP_W = 6
  - error bit indices ERR_FRAME = 0, ERR_SAT = 1
  - FSM enum {IDLE, INFRAME}
  - the shared saturate function
- Sub-module fft_bfp_shift_sat is natural: combinational signed shift plus saturate for one component, instantiated twice in stage 1.

## Test plan
- exp=0, real=100, imag=−200 → out 100/−200, power 50000, error 0, output 2 cycles after the accept.
- exp=−3, real=1000 → 8000. exp=2, real=1000 → 250; real=−5 → −2. Exponent changed mid-frame is ignored.
- exp=0, real=40000, imag=−40000 → 32767/−32768, out_error=2'b10, power 2147418113.
- FFT_N=8:
  - eop on beat 5 → beat 5 emits eop with error bit0.
  - The following non-sop beat is dropped and err_sticky[0]=1.
  - A frame with no eop gets eop forced on beat 7.
- Random out_ready, including a 3-cycle low mid-frame → in_ready low, outputs held, scoreboard shows an exact in-order match.
- Reset asserted at beat 4 of a frame → all outputs 0 next cycle; the next sop frame processes normally.

Source files
------------

// File: rtl/fft_bfp_normalizer_pkg.sv
// Shared constants, types and the saturation helper for the block-floating-point normalizer.
package fft_pkg;

    localparam int EXP_W     = 6;
    localparam int ERR_FRAME = 0;
    localparam int ERR_SAT   = 1;
    // Wide enough for a 32-bit sample shifted left by 32 without losing bits.
    localparam int WIDE_W    = 64;

    typedef enum logic {IDLE, INFRAME} state_t;

    typedef struct packed {
        logic signed [WIDE_W-1:0] value;
        logic                     clip;
    } sat_t;

    function automatic sat_t saturate(input logic signed [WIDE_W-1:0] v, input int unsigned width);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        sat_t                     r;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        r.clip  = (v > hi) || (v < lo);
        r.value = (v > hi) ? hi : ((v < lo) ? lo : v);
        return r;
    endfunction

endpackage

// File: rtl/fft_bfp_normalizer_if.sv
// Input BFP stream plus output fixed-scale stream, with the DUT on the slave side.
interface fft_bfp_normalizer_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    import fft_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [1:0]              in_error;
    logic                    in_sop;
    logic                    in_eop;
    logic signed [IN_W-1:0]  in_real;
    logic signed [IN_W-1:0]  in_imag;
    logic signed [EXP_W-1:0] in_exp;
    logic                    out_valid;
    logic                    out_ready;
    logic [1:0]              out_error;
    logic                    out_sop;
    logic                    out_eop;
    logic signed [OUT_W-1:0] out_real;
    logic signed [OUT_W-1:0] out_imag;
    logic [2*OUT_W-1:0]      out_power;
    logic [1:0]              err_sticky;

    modport master (
        output in_valid, in_error, in_sop, in_eop, in_real, in_imag, in_exp, out_ready,
        input  in_ready, out_valid, out_error, out_sop, out_eop, out_real, out_imag,
               out_power, err_sticky
    );

    modport slave (
        input  in_valid, in_error, in_sop, in_eop, in_real, in_imag, in_exp, out_ready,
        output in_ready, out_valid, out_error, out_sop, out_eop, out_real, out_imag,
               out_power, err_sticky
    );

endinterface

// File: rtl/fft_bfp_normalizer_shift_sat.sv
// One component: apply 2^(-exp) (left shift or flooring right shift), then saturate to OUT_W.
module fft_bfp_shift_sat
    import fft_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    input  logic signed [EXP_W-1:0] exp,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    logic signed [WIDE_W-1:0] wide;
    logic signed [WIDE_W-1:0] shifted;
    logic signed [EXP_W:0]    shift;
    logic        [EXP_W:0]    mag;
    sat_t                     res;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wide    = WIDE_W'(din);
        shifted = wide;
        mag     = '0;
        // One extra bit so exp = -32 becomes a shift of +32.
        shift   = -$signed({exp[EXP_W-1], exp});
        if (!shift[EXP_W]) begin
            shifted = wide <<< shift[EXP_W-1:0];
        end else begin
            mag     = -shift;
            shifted = wide >>> mag[EXP_W-1:0];
        end
        res  = saturate(shifted, OUT_W);
        dout = res.value[OUT_W-1:0];
        clip = res.clip;
    end

endmodule

// File: rtl/fft_bfp_normalizer.sv
// BFP-to-fixed normalizer: framing FSM + shift/saturate (stage 1), power (stage 2), stall-all flow.
module fft_bfp_normalizer
    import fft_pkg::*;
#(
    parameter int FFT_N = 1024,
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input logic clk,
    input logic reset,
    fft_bfp_normalizer_if.slave bus
);

    localparam int CNT_W = $clog2(FFT_N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FFT_N - 1);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        count, count_n;
    logic signed [EXP_W-1:0] exp_q, exp_n, exp_use;
    logic                    emit, beat_sop, beat_eop, frame_err, drop;
    logic                    fire, s1_en, s2_en;
    logic signed [OUT_W-1:0] sh_real, sh_imag;
    logic                    clip_real, clip_imag;

    logic                    s1_valid, s1_sop, s1_eop;
    logic [1:0]              s1_err;
    logic signed [OUT_W-1:0] s1_real, s1_imag;
    logic                    s2_valid, s2_sop, s2_eop;
    logic [1:0]              s2_err;
    logic signed [OUT_W-1:0] s2_real, s2_imag;
    logic [2*OUT_W-1:0]      s2_power;
    logic [1:0]              sticky;

    logic signed [2*OUT_W-1:0] re_x, im_x, sq_re, sq_im;
    logic [2*OUT_W-1:0]        power_n;

    // A stage may load when the stage after it moves or it is itself empty.
    assign s2_en   = bus.out_ready || !s2_valid;
    assign s1_en   = s2_en || !s1_valid;
    assign fire    = bus.in_valid && s1_en;
    assign exp_use = bus.in_sop ? bus.in_exp : exp_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state <= IDLE;
            count <= '0;
            exp_q <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            exp_q <= exp_n;
        end
    end

    always_comb begin
        state_n = state; count_n = count; exp_n = exp_q;
        emit = 1'b0; beat_sop = 1'b0; beat_eop = 1'b0; frame_err = 1'b0; drop = 1'b0;
        if (fire) begin
            if (bus.in_sop) begin
                // A sop while already in a frame restarts the frame and flags it.
                emit = 1'b1; beat_sop = 1'b1; frame_err = (state == INFRAME);
                exp_n = bus.in_exp; count_n = CNT_W'(1); state_n = INFRAME;
                if (bus.in_eop) begin
                    beat_eop = 1'b1; frame_err = 1'b1; count_n = '0; state_n = IDLE;
                end
            end else begin
                case (state)
                    IDLE: drop = 1'b1;
                    INFRAME: begin
                        emit = 1'b1;
                        if (count == LAST || bus.in_eop) begin
                            beat_eop  = 1'b1;
                            frame_err = (count != LAST) || !bus.in_eop;
                            count_n   = '0;
                            state_n   = IDLE;
                        end else begin
                            count_n = count + CNT_W'(1);
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    fft_bfp_shift_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_real (
        .din(bus.in_real), .exp(exp_use), .dout(sh_real), .clip(clip_real)
    );
    fft_bfp_shift_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sat_imag (
        .din(bus.in_imag), .exp(exp_use), .dout(sh_imag), .clip(clip_imag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0; s1_sop <= 1'b0; s1_eop <= 1'b0; s1_err <= '0;
            s1_real  <= '0;   s1_imag <= '0;
        end else if (s1_en) begin
            s1_valid <= emit;
            if (emit) begin
                s1_sop  <= beat_sop;
                s1_eop  <= beat_eop;
                s1_err[ERR_FRAME] <= frame_err || (bus.in_error != 2'b00);
                s1_err[ERR_SAT]   <= clip_real || clip_imag;
                s1_real <= sh_real;
                s1_imag <= sh_imag;
            end
        end
    end

    // Sum of squares fits unsigned 2*OUT_W bits: at most 2 * 2^(2*OUT_W-2).
    assign re_x    = (2*OUT_W)'(s1_real);
    assign im_x    = (2*OUT_W)'(s1_imag);
    assign sq_re   = re_x * re_x;
    assign sq_im   = im_x * im_x;
    assign power_n = $unsigned(sq_re) + $unsigned(sq_im);

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0; s2_sop <= 1'b0; s2_eop <= 1'b0; s2_err <= '0;
            s2_real  <= '0;   s2_imag <= '0;  s2_power <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sop   <= s1_sop;
                s2_eop   <= s1_eop;
                s2_err   <= s1_err;
                s2_real  <= s1_real;
                s2_imag  <= s1_imag;
                s2_power <= power_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= sticky
                    | ((s2_en && s1_valid) ? s1_err : 2'b00)
                    | (2'(drop) << ERR_FRAME);
        end
    end

    assign bus.in_ready   = s1_en;
    assign bus.out_valid  = s2_valid;
    assign bus.out_sop    = s2_sop;
    assign bus.out_eop    = s2_eop;
    assign bus.out_error  = s2_err;
    assign bus.out_real   = s2_real;
    assign bus.out_imag   = s2_imag;
    assign bus.out_power  = s2_power;
    assign bus.err_sticky = sticky;

endmodule
